prism_sp_tx_irq_coalescer: RTL and testbench

PRISM_SP_TX_IRQ_COALESCER -- requirements
Module: prism_sp_tx_irq_coalescer

---
 rtl/prism_sp_tx_irq_coalescer.sv | 152 +++++++++++++++
 tb/tb_prism_sp_tx_irq_coalescer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/prism_sp_tx_irq_coalescer.sv
// ---------------------------------------------------------------------------
// prism_sp_tx_irq_coalescer
//
// Aggregates per-queue TX completion pulses into a single level interrupt.
// Completions are accumulated until a count threshold is reached or a
// coalescing timer expires. Software acknowledges by clearing pending bits;
// once no queue is pending, the interrupt drops.
//
// Ports:
//   clock         sole clock, rising edge
//   reset         asynchronous, active-high reset
//   queue_txdone  per-queue single-cycle completion pulses
//   irq_mask      per-queue enable (1 = completions accepted)
//   coal_count    completion threshold, 0 behaves as 1 (read every cycle)
//   coal_timeout  timeout in cycles, 0 disables timer (sampled at timer load)
//   clear_valid   acknowledge strobe
//   clear_mask    write-1-to-clear selection of pending bits
//   pending       registered per-queue pending flags
//   gem_irq_tx    registered level interrupt (high exactly in FIRE)
//   event_count   registered, saturating count of accepted completions
// ---------------------------------------------------------------------------
module prism_sp_tx_irq_coalescer #(
    parameter int NUM_QUEUES = 2,
    parameter int CNT_WIDTH  = 8,
    parameter int TMR_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_QUEUES-1:0] queue_txdone,
    input  logic [NUM_QUEUES-1:0] irq_mask,
    input  logic [CNT_WIDTH-1:0]  coal_count,
    input  logic [TMR_WIDTH-1:0]  coal_timeout,
    input  logic                  clear_valid,
    input  logic [NUM_QUEUES-1:0] clear_mask,
    output logic [NUM_QUEUES-1:0] pending,
    output logic                  gem_irq_tx,
    output logic [CNT_WIDTH-1:0]  event_count
);

    // Sum is wide enough to hold the counter plus a popcount of up to 32.
    localparam int SUM_W = CNT_WIDTH + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_WIDTH) - SUM_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_QUEUES-1:0]   pending_q, pending_d;
    logic [CNT_WIDTH-1:0]    event_count_q, event_count_d;
    logic [TMR_WIDTH-1:0]    timer_q, timer_d;
    logic                    timer_en_q, timer_en_d;

    logic [NUM_QUEUES-1:0]   accepted;
    logic [5:0]              acc_pop;
    logic [SUM_W-1:0]        cnt_sum;
    logic [CNT_WIDTH-1:0]    cnt_sat;
    logic [CNT_WIDTH-1:0]    thresh;
    logic                    thresh_hit;
    logic                    timer_expire;

    assign accepted = queue_txdone & irq_mask;

    // A same-cycle accepted event beats the clear on its own bit.
    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_pend
        assign pending_d[gi] = accepted[gi] |
                               (pending_q[gi] & ~(clear_valid & clear_mask[gi]));
    end

    always_comb begin
        acc_pop = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            acc_pop = acc_pop + 6'(accepted[i]);
        end
    end

    // event_count_q is zero in IDLE, so the same saturating sum serves all states.
    assign cnt_sum      = SUM_W'(event_count_q) + SUM_W'(acc_pop);
    assign cnt_sat      = (cnt_sum > CNT_MAX) ? CNT_WIDTH'(CNT_MAX) : CNT_WIDTH'(cnt_sum);
    assign thresh       = (coal_count == '0) ? CNT_WIDTH'(1) : coal_count;
    assign thresh_hit   = (cnt_sat >= thresh);
    assign timer_expire = timer_en_q && (timer_q == TMR_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        event_count_d = cnt_sat;
        timer_d       = timer_q;
        timer_en_d    = timer_en_q;
        case (state_q)
            ST_IDLE: begin
                event_count_d = '0;
                if (|accepted) begin
                    event_count_d = cnt_sat;
                    timer_d       = coal_timeout;
                    timer_en_d    = (coal_timeout != '0);
                    state_d       = thresh_hit ? ST_FIRE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (timer_en_q && (timer_q != '0)) begin
                    timer_d = timer_q - TMR_WIDTH'(1);
                end
                // Fully acknowledged before firing: drop back silently.
                if (pending_d == '0) begin
                    state_d       = ST_IDLE;
                    event_count_d = '0;
                    timer_d       = '0;
                    timer_en_d    = 1'b0;
                end else if (thresh_hit || timer_expire) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                timer_d    = '0;
                timer_en_d = 1'b0;
                if (pending_d == '0) begin
                    state_d       = ST_IDLE;
                    event_count_d = '0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                event_count_d = '0;
                timer_d       = '0;
                timer_en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            event_count_q <= '0;
            timer_q       <= '0;
            timer_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            event_count_q <= event_count_d;
            timer_q       <= timer_d;
            timer_en_q    <= timer_en_d;
        end
    end

    assign pending     = pending_q;
    assign event_count = event_count_q;
    assign gem_irq_tx  = (state_q == ST_FIRE);

endmodule

// File: tb/tb_prism_sp_tx_irq_coalescer.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for prism_sp_tx_irq_coalescer.
// u_dut  : NUM_QUEUES=2, CNT_WIDTH=8, TMR_WIDTH=16
// u_dut2 : NUM_QUEUES=2, CNT_WIDTH=2 (saturation and async reset)
// ---------------------------------------------------------------------------
module tb_prism_sp_tx_irq_coalescer;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // u_dut signals
    logic        reset;
    logic [1:0]  queue_txdone, irq_mask, clear_mask, pending;
    logic [7:0]  coal_count, event_count;
    logic [15:0] coal_timeout;
    logic        clear_valid, gem_irq_tx;

    // u_dut2 signals
    logic        reset2;
    logic [1:0]  queue_txdone2, irq_mask2, clear_mask2, pending2;
    logic [1:0]  coal_count2, event_count2;
    logic [15:0] coal_timeout2;
    logic        clear_valid2, gem_irq_tx2;

    int n_checks = 0;
    int n_fail   = 0;

    prism_sp_tx_irq_coalescer #(.NUM_QUEUES(2), .CNT_WIDTH(8), .TMR_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .queue_txdone(queue_txdone), .irq_mask(irq_mask),
        .coal_count(coal_count), .coal_timeout(coal_timeout), .clear_valid(clear_valid),
        .clear_mask(clear_mask), .pending(pending), .gem_irq_tx(gem_irq_tx),
        .event_count(event_count)
    );

    prism_sp_tx_irq_coalescer #(.NUM_QUEUES(2), .CNT_WIDTH(2), .TMR_WIDTH(16)) u_dut2 (
        .clock(clock), .reset(reset2), .queue_txdone(queue_txdone2), .irq_mask(irq_mask2),
        .coal_count(coal_count2), .coal_timeout(coal_timeout2), .clear_valid(clear_valid2),
        .clear_mask(clear_mask2), .pending(pending2), .gem_irq_tx(gem_irq_tx2),
        .event_count(event_count2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One transaction on u_dut: drive for one edge, then release the strobes.
    task automatic cycle1(input logic [1:0] txd, input logic clr_v, input logic [1:0] clr_m);
        queue_txdone = txd;
        clear_valid  = clr_v;
        clear_mask   = clr_m;
        tick();
        queue_txdone = 2'b00;
        clear_valid  = 1'b0;
        clear_mask   = 2'b00;
        $display("txn dut1 txdone=%b clr=%b/%b -> pending=%b irq=%b cnt=%0d",
                 txd, clr_v, clr_m, pending, gem_irq_tx, event_count);
    endtask

    task automatic cycle2(input logic [1:0] txd);
        queue_txdone2 = txd;
        tick();
        queue_txdone2 = 2'b00;
        $display("txn dut2 txdone=%b -> pending=%b irq=%b cnt=%0d",
                 txd, pending2, gem_irq_tx2, event_count2);
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        tick(); tick();
        n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL reset_pending got %b exp 00", pending); end
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", gem_irq_tx); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", event_count); end
        reset = 1'b0; reset2 = 1'b0;
        tick();
    endtask

    task automatic test_single_event();
        irq_mask = 2'b11; coal_count = 8'd1; coal_timeout = 16'd0;
        cycle1(2'b01, 1'b0, 2'b00);
        n_checks++; if (pending !== 2'b01) begin n_fail++; $display("FAIL single_pending got %b exp 01", pending); end
        n_checks++; if (gem_irq_tx !== 1'b1) begin n_fail++; $display("FAIL single_irq got %b exp 1", gem_irq_tx); end
        n_checks++; if (event_count !== 8'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", event_count); end
        cycle1(2'b00, 1'b1, 2'b01);
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL single_clr_irq got %b exp 0", gem_irq_tx); end
        n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL single_clr_pending got %b exp 00", pending); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL single_clr_cnt got %0d exp 0", event_count); end
    endtask

    task automatic test_threshold();
        irq_mask = 2'b11; coal_count = 8'd4; coal_timeout = 16'd0;
        cycle1(2'b11, 1'b0, 2'b00);
        n_checks++; if (event_count !== 8'd2) begin n_fail++; $display("FAIL thr_cnt1 got %0d exp 2", event_count); end
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL thr_irq1 got %b exp 0", gem_irq_tx); end
        cycle1(2'b00, 1'b0, 2'b00);
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL thr_irq_gap got %b exp 0", gem_irq_tx); end
        cycle1(2'b11, 1'b0, 2'b00);
        n_checks++; if (event_count !== 8'd4) begin n_fail++; $display("FAIL thr_cnt2 got %0d exp 4", event_count); end
        n_checks++; if (gem_irq_tx !== 1'b1) begin n_fail++; $display("FAIL thr_irq2 got %b exp 1", gem_irq_tx); end
        cycle1(2'b00, 1'b1, 2'b11);
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL thr_clr_irq got %b exp 0", gem_irq_tx); end
    endtask

    task automatic test_timeout();
        irq_mask = 2'b11; coal_count = 8'd8; coal_timeout = 16'd10;
        cycle1(2'b01, 1'b0, 2'b00);
        // Timeout is only sampled at load; changing it now must not matter.
        coal_timeout = 16'd0;
        n_checks++; if (event_count !== 8'd1) begin n_fail++; $display("FAIL tmo_cnt_entry got %0d exp 1", event_count); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL tmo_early cycle %0d got %b exp 0", k, gem_irq_tx); end
        end
        tick();
        n_checks++; if (gem_irq_tx !== 1'b1) begin n_fail++; $display("FAIL tmo_fire got %b exp 1", gem_irq_tx); end
        n_checks++; if (event_count !== 8'd1) begin n_fail++; $display("FAIL tmo_cnt got %0d exp 1", event_count); end
        cycle1(2'b00, 1'b1, 2'b01);
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL tmo_clr_irq got %b exp 0", gem_irq_tx); end
    endtask

    task automatic test_masked();
        irq_mask = 2'b10; coal_count = 8'd1; coal_timeout = 16'd0;
        for (int k = 0; k < 3; k++) begin
            cycle1(2'b01, 1'b0, 2'b00);
            n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL mask_pending got %b exp 00", pending); end
            n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL mask_irq got %b exp 0", gem_irq_tx); end
            n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL mask_cnt got %0d exp 0", event_count); end
        end
    endtask

    task automatic test_clear_vs_event();
        irq_mask = 2'b11; coal_count = 8'd1; coal_timeout = 16'd0;
        cycle1(2'b01, 1'b0, 2'b00);
        cycle1(2'b01, 1'b1, 2'b01);
        n_checks++; if (pending !== 2'b01) begin n_fail++; $display("FAIL race_pending got %b exp 01", pending); end
        n_checks++; if (gem_irq_tx !== 1'b1) begin n_fail++; $display("FAIL race_irq got %b exp 1", gem_irq_tx); end
        n_checks++; if (event_count !== 8'd2) begin n_fail++; $display("FAIL race_cnt got %0d exp 2", event_count); end
        // Clear queue 0 while queue 1 completes: both applied together.
        cycle1(2'b10, 1'b1, 2'b01);
        n_checks++; if (pending !== 2'b10) begin n_fail++; $display("FAIL mix_pending got %b exp 10", pending); end
        n_checks++; if (gem_irq_tx !== 1'b1) begin n_fail++; $display("FAIL mix_irq got %b exp 1", gem_irq_tx); end
        cycle1(2'b00, 1'b1, 2'b10);
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL mix_clr_irq got %b exp 0", gem_irq_tx); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL mix_clr_cnt got %0d exp 0", event_count); end
    endtask

    task automatic test_accum_clear();
        irq_mask = 2'b11; coal_count = 8'd4; coal_timeout = 16'd0;
        cycle1(2'b01, 1'b0, 2'b00);
        cycle1(2'b00, 1'b1, 2'b01);
        n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL acclr_pending got %b exp 00", pending); end
        n_checks++; if (event_count !== 8'd0) begin n_fail++; $display("FAIL acclr_cnt got %0d exp 0", event_count); end
        n_checks++; if (gem_irq_tx !== 1'b0) begin n_fail++; $display("FAIL acclr_irq got %b exp 0", gem_irq_tx); end
        // Back in IDLE: a fresh episode counts from one.
        cycle1(2'b01, 1'b0, 2'b00);
        n_checks++; if (event_count !== 8'd1) begin n_fail++; $display("FAIL acclr_restart got %0d exp 1", event_count); end
        cycle1(2'b00, 1'b1, 2'b01);
    endtask

    task automatic test_saturate_and_reset();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        irq_mask2 = 2'b11; coal_count2 = 2'd0; coal_timeout2 = 16'd0;
        for (int k = 0; k < 5; k++) begin
            cycle2(2'b01);
            n_checks++; if (event_count2 !== 2'(exp_cnt[k])) begin n_fail++; $display("FAIL sat_cnt ev %0d got %0d exp %0d", k, event_count2, exp_cnt[k]); end
            n_checks++; if (gem_irq_tx2 !== 1'b1) begin n_fail++; $display("FAIL sat_irq ev %0d got %b exp 1", k, gem_irq_tx2); end
        end
        // Assert reset between edges: outputs must fall without a clock edge.
        #2 reset2 = 1'b1;
        #1;
        n_checks++; if (gem_irq_tx2 !== 1'b0) begin n_fail++; $display("FAIL areset_irq got %b exp 0", gem_irq_tx2); end
        n_checks++; if (pending2 !== 2'b00) begin n_fail++; $display("FAIL areset_pending got %b exp 00", pending2); end
        n_checks++; if (event_count2 !== 2'd0) begin n_fail++; $display("FAIL areset_cnt got %0d exp 0", event_count2); end
        cycle2(2'b11);
        reset2 = 1'b0;
        tick();
        n_checks++; if (pending2 !== 2'b00) begin n_fail++; $display("FAIL lost_pending got %b exp 00", pending2); end
        n_checks++; if (gem_irq_tx2 !== 1'b0) begin n_fail++; $display("FAIL lost_irq got %b exp 0", gem_irq_tx2); end
    endtask

    initial begin
        queue_txdone  = 2'b00; irq_mask  = 2'b11; clear_mask  = 2'b00; clear_valid  = 1'b0;
        coal_count    = 8'd1;  coal_timeout  = 16'd0;
        queue_txdone2 = 2'b00; irq_mask2 = 2'b11; clear_mask2 = 2'b00; clear_valid2 = 1'b0;
        coal_count2   = 2'd1;  coal_timeout2 = 16'd0;
        reset = 1'b1; reset2 = 1'b1;

        test_reset();
        test_single_event();
        test_threshold();
        test_timeout();
        test_masked();
        test_clear_vs_event();
        test_accum_clear();
        test_saturate_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
